// File: rtl/id_stage_if.sv
// id_stage_if: fetch-to-decode handshake
// if_valid/if_instr/if_pc flow from fetch to decode; id_ready flows back
interface id_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  modport master (output if_valid, if_instr, if_pc, input id_ready);
  modport slave (input if_valid, if_instr, if_pc, output id_ready);
endinterface

// File: rtl/id_stage.sv
// id_stage: MIPS-subset decode stage with WB bypass, load-use stall and ID/EX register
// ports: clk, reset (sync active-low), bus (fetch handshake), rf_addr_*/rf_data_* (regfile read),
//        wb_addr/wb_data/write (writeback), ex_ready/flush (execute control), ex_* (registered ID/EX outputs)
module id_stage (
  input  logic        clk,
  input  logic        reset,
  id_stage_if.slave   bus,
  output logic [4:0]  rf_addr_1,
  output logic [4:0]  rf_addr_2,
  input  logic [31:0] rf_data_1,
  input  logic [31:0] rf_data_2,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        write,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_alu_op,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_illegal
);
  logic [31:0] instr;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic        is_r, is_nop, is_addi, is_lw, is_sw, is_beq, illegal, uses_rt, hazard;
  logic        reg_write;
  logic [2:0]  alu_op;
  logic [31:0] op1, op2;
  assign instr = bus.if_instr;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rf_addr_1 = rs;
  assign rf_addr_2 = rt;
  always_comb begin
    is_r = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
    is_nop = instr == 32'h0;
    is_addi = op == 6'h08;
    is_lw = op == 6'h23;
    is_sw = op == 6'h2B;
    is_beq = op == 6'h04;
    illegal = !(is_r || is_nop || is_addi || is_lw || is_sw || is_beq);
    alu_op = is_r ? (fn == 6'h22 ? 3'd1 : fn == 6'h24 ? 3'd2 : fn == 6'h25 ? 3'd3 : fn == 6'h2A ? 3'd4 : 3'd0)
           : is_beq ? 3'd1 : 3'd0;
    rd = is_r ? instr[15:11] : (is_addi || is_lw) ? rt : 5'd0;
    reg_write = is_r || is_addi || is_lw;
    uses_rt = op == 6'h00 || is_sw || is_beq;
    // register 0 reads as zero, which also keeps a write to $0 from bypassing
    op1 = rs == 5'd0 ? 32'h0 : (write && wb_addr == rs) ? wb_data : rf_data_1;
    op2 = rt == 5'd0 ? 32'h0 : (write && wb_addr == rt) ? wb_data : rf_data_2;
    hazard = ex_valid && ex_mem_read && ex_rd != 5'd0 && (ex_rd == rs || (uses_rt && ex_rd == rt)) && bus.if_valid;
  end
  assign bus.id_ready = flush || (ex_ready && !hazard);
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_op1 <= '0;
      ex_op2 <= '0;
      ex_imm <= '0;
      ex_rd <= '0;
      ex_alu_op <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_ready) begin
      if (hazard || !bus.if_valid) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= 1'b1;
        ex_pc <= bus.if_pc;
        ex_op1 <= op1;
        ex_op2 <= op2;
        ex_imm <= {{16{instr[15]}}, instr[15:0]};
        ex_rd <= rd;
        ex_alu_op <= alu_op;
        ex_reg_write <= reg_write;
        ex_mem_read <= is_lw;
        ex_mem_write <= is_sw;
        ex_branch <= is_beq;
        ex_illegal <= illegal;
      end
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors with hand-computed expectations for id_stage
module tb_id_stage;
  logic        clk, reset;
  logic [4:0]  rf_addr_1, rf_addr_2, wb_addr, ex_rd;
  logic [31:0] rf_data_1, rf_data_2, wb_data;
  logic        write, ex_ready, flush;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [2:0]  ex_alu_op;
  int          total = 0, bad = 0;
  id_stage_if bus ();
  id_stage dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .wb_addr(wb_addr), .wb_data(wb_data), .write(write), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task cyc;
    @(posedge clk);
    #1;
  endtask
  task drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc = pc;
    rf_data_1 = d1;
    rf_data_2 = d2;
    #1;
  endtask
  task ctl(input string tag, input logic [2:0] alu, input logic [4:0] rd, input logic rw, input logic mr,
           input logic mw, input logic br, input logic ill);
    chk({tag, ".valid"}, {31'b0, ex_valid}, 1);
    chk({tag, ".alu"}, {29'b0, ex_alu_op}, {29'b0, alu});
    chk({tag, ".rd"}, {27'b0, ex_rd}, {27'b0, rd});
    chk({tag, ".ctl"}, {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal},
        {27'b0, rw, mr, mw, br, ill});
  endtask
  initial begin
    reset = 0; write = 0; wb_addr = 0; wb_data = 0; ex_ready = 1; flush = 0;
    drive(1, 32'h00221820, 32'h100, 5, 7);
    cyc;
    chk("rst.valid", {31'b0, ex_valid}, 0);
    chk("rst.pc", ex_pc, 0);
    chk("rst.op1", ex_op1, 0);
    chk("rst.rd", {27'b0, ex_rd}, 0);
    chk("rst.ready", {31'b0, bus.id_ready}, 1);
    reset = 1;
    // add $3,$1,$2
    drive(1, 32'h00221820, 32'h100, 5, 7);
    chk("add.rs", {27'b0, rf_addr_1}, 1);
    chk("add.rt", {27'b0, rf_addr_2}, 2);
    chk("add.ready", {31'b0, bus.id_ready}, 1);
    cyc;
    ctl("add", 0, 3, 1, 0, 0, 0, 0);
    chk("add.op1", ex_op1, 5);
    chk("add.op2", ex_op2, 7);
    chk("add.pc", ex_pc, 32'h100);
    chk("add.imm", ex_imm, 32'h1820);
    // bypass from writeback on rs
    write = 1; wb_addr = 1; wb_data = 32'h99;
    drive(1, 32'h00221820, 32'h104, 5, 7);
    cyc;
    chk("byp.op1", ex_op1, 32'h99);
    chk("byp.op2", ex_op2, 7);
    wb_addr = 0;
    drive(1, 32'h00221820, 32'h108, 5, 7);
    cyc;
    chk("byp0.op1", ex_op1, 5);
    // rs=$0 reads zero even with data present
    drive(1, 32'h00021820, 32'h10C, 32'h55, 7);
    cyc;
    chk("r0.op1", ex_op1, 0);
    write = 0;
    drive(1, 32'h00221822, 32'h110, 1, 2);
    cyc;
    ctl("sub", 1, 3, 1, 0, 0, 0, 0);
    drive(1, 32'h0022182A, 32'h114, 1, 2);
    cyc;
    ctl("slt", 4, 3, 1, 0, 0, 0, 0);
    drive(1, 32'h00221825, 32'h118, 1, 2);
    cyc;
    ctl("or", 3, 3, 1, 0, 0, 0, 0);
    // addi $6,$1,-1
    drive(1, 32'h2026FFFF, 32'h11C, 1, 2);
    cyc;
    ctl("addi", 0, 6, 1, 0, 0, 0, 0);
    chk("addi.imm", ex_imm, 32'hFFFFFFFF);
    // sw $2,-4($1)
    drive(1, 32'hAC22FFFC, 32'h120, 1, 32'h22);
    cyc;
    ctl("sw", 0, 0, 0, 0, 1, 0, 0);
    chk("sw.imm", ex_imm, 32'hFFFFFFFC);
    chk("sw.op2", ex_op2, 32'h22);
    drive(1, 32'h10220003, 32'h124, 1, 2);
    cyc;
    ctl("beq", 1, 0, 0, 0, 0, 1, 0);
    // lw $4,8($1) then add $5,$4,$4: one bubble
    drive(1, 32'h8C240008, 32'h200, 1, 2);
    cyc;
    ctl("lw", 0, 4, 1, 1, 0, 0, 0);
    chk("lw.imm", ex_imm, 8);
    drive(1, 32'h00842820, 32'h204, 32'h44, 32'h44);
    chk("lu.ready", {31'b0, bus.id_ready}, 0);
    cyc;
    chk("lu.bubble", {31'b0, ex_valid}, 0);
    chk("lu.ready2", {31'b0, bus.id_ready}, 1);
    cyc;
    ctl("lu.add", 0, 5, 1, 0, 0, 0, 0);
    chk("lu.pc", ex_pc, 32'h204);
    chk("lu.op1", ex_op1, 32'h44);
    // lw then addi reading loaded reg only as rt-destination: no hazard
    drive(1, 32'h8C240008, 32'h210, 1, 2);
    cyc;
    drive(1, 32'h20240001, 32'h214, 1, 2);
    chk("nohz.ready", {31'b0, bus.id_ready}, 1);
    cyc;
    ctl("nohz", 0, 4, 1, 0, 0, 0, 0);
    // backpressure: three stalled cycles, registered values persist
    drive(1, 32'h00842820, 32'h300, 32'h44, 32'h45);
    cyc;
    ex_ready = 0;
    drive(1, 32'h00221822, 32'h304, 32'hAA, 32'hBB);
    for (int i = 0; i < 3; i++) begin
      chk("stall.ready", {31'b0, bus.id_ready}, 0);
      cyc;
      chk("stall.valid", {31'b0, ex_valid}, 1);
      chk("stall.pc", ex_pc, 32'h300);
      chk("stall.op2", ex_op2, 32'h45);
      chk("stall.rd", {27'b0, ex_rd}, 5);
    end
    ex_ready = 1;
    drive(1, 32'h00221822, 32'h304, 32'hAA, 32'hBB);
    cyc;
    ctl("rel", 1, 3, 1, 0, 0, 0, 0);
    chk("rel.op1", ex_op1, 32'hAA);
    // flush overrides backpressure
    ex_ready = 0; flush = 1;
    drive(1, 32'h00221820, 32'h400, 1, 2);
    chk("fl.ready", {31'b0, bus.id_ready}, 1);
    cyc;
    chk("fl.valid", {31'b0, ex_valid}, 0);
    ex_ready = 1; flush = 0;
    drive(1, 32'hFC000000, 32'h404, 1, 2);
    cyc;
    ctl("ill.op", 0, 0, 0, 0, 0, 0, 1);
    drive(1, 32'h00221821, 32'h408, 1, 2);
    cyc;
    ctl("ill.fn", 0, 0, 0, 0, 0, 0, 1);
    drive(1, 32'h00000000, 32'h40C, 1, 2);
    cyc;
    ctl("nop", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 32'h00221820, 32'h410, 1, 2);
    cyc;
    chk("idle.valid", {31'b0, ex_valid}, 0);
    // reset during a stall discards the held instruction
    drive(1, 32'h00221820, 32'h500, 1, 2);
    cyc;
    ex_ready = 0; reset = 0;
    drive(1, 32'h00221822, 32'h504, 1, 2);
    cyc;
    chk("rs.valid", {31'b0, ex_valid}, 0);
    chk("rs.pc", ex_pc, 0);
    chk("rs.ctl", {29'b0, ex_reg_write, ex_alu_op[1:0]}, 0);
    reset = 1; ex_ready = 1;
    drive(1, 32'h00221820, 32'h508, 3, 4);
    cyc;
    ctl("post", 0, 3, 1, 0, 0, 0, 0);
    chk("post.pc", ex_pc, 32'h508);
    chk("post.op2", ex_op2, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: none; opcode/funct encodings are fixed by REQ-016.
REQ-002 clk  in  1  rising-edge clock, sole clock.
REQ-003 reset  in  1  synchronous, active-low; sampled on rising clk only.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_instr  in  32  instruction word.
REQ-006 if_pc  in  32  PC of if_instr.
REQ-007 id_ready  out  1  instruction accepted this cycle.
REQ-008 rf_addr_1 / rf_addr_2  out  5 each  register file read addresses, rs = if_instr[25:21] and rt = if_instr[20:16], combinational.
REQ-009 rf_data_1 / rf_data_2  in  32 each  register file read data, combinational, same cycle as address.
REQ-010 wb_addr  in  5, wb_data  in  32, write  in  1  writeback port, the same signals driven into the register file.
REQ-011 ex_ready  in  1  execute stage can accept; flush  in  1  discard the ID instruction and the pipeline register.
REQ-012 ex_valid  out  1; ex_pc  out  32; ex_op1, ex_op2  out  32 each; ex_imm  out  32; ex_rd  out  5; ex_alu_op  out  3; ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal  out  1 each. All registered.

Function
REQ-013 Operand bypass: op1 = wb_data when write=1, wb_addr!=0 and wb_addr==rs, else rf_data_1. op2 uses the same rule on rt.
REQ-014 Register 0 operand is 0 regardless of rf_data or bypass.
REQ-015 ex_imm = sign-extension of if_instr[15:0].
REQ-016 Decode, giving ex_alu_op / rd / controls:
- op 0x00 funct 0x20 add=0, 0x22 sub=1, 0x24 and=2, 0x25 or=3, 0x2A slt=4; rd=instr[15:11]; reg_write=1.
- op 0x08 addi: alu 0; rd=rt; reg_write=1.
- op 0x23 lw: alu 0; rd=rt; reg_write=1; mem_read=1.
- op 0x2B sw: alu 0; rd=0; mem_write=1.
- op 0x04 beq: alu 1; rd=0; branch=1.
REQ-017 Any other opcode or R-type funct: all controls 0, rd=0, alu_op=0, ex_illegal=1.
REQ-018 Instruction word 0x00000000 (sll $0) decodes as add to rd=0 with reg_write=0, and ex_illegal=0.
REQ-019 uses_rt=1 for R-type, sw and beq; 0 otherwise.
REQ-020 Load-use hazard = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs | (uses_rt & ex_rd==rt)) & if_valid.
REQ-021 id_ready = flush | (ex_ready & ~hazard).
REQ-022 Edge priority: reset, then flush, then hold, then load.
- flush=1: ex_valid<=0; the ID instruction is consumed and dropped.
- else if ex_ready=0: all ex_* hold.
- else if hazard or if_valid=0: ex_valid<=0 (bubble); other ex_* do not care.
- else: load all ex_* from the decode and operands, ex_valid<=1.
REQ-023 Latency: 1 cycle from acceptance to ex_valid; throughput 1 per cycle without hazard or backpressure.
REQ-024 A held instruction re-samples no operands; the registered values persist unchanged through stall.

Reset
REQ-025 On rising clk with reset=0, all ex_* outputs become 0, overriding flush and ex_ready.
REQ-026 A reset during stall or hazard discards the pending instruction.
REQ-027 id_ready is combinational and follows REQ-021 during reset, using the reset-state ex_valid=0.

Verification
REQ-028 add $3,$1,$2 (0x00221820), rf_data 5/7, ex_ready=1 -> next cycle ex_valid=1, op1=5, op2=7, rd=3, alu_op=0, reg_write=1.
REQ-029 Same add with write=1, wb_addr=1, wb_data=0x99 -> op1=0x99. Repeat with wb_addr=0 -> op1=rf_data_1.
REQ-030 lw $4,8($1) followed by add $5,$4,$4 -> add cycle id_ready=0, next ex_valid=0 (bubble), add accepted one cycle later.
REQ-031 ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable, id_ready=0. Then ex_ready=1 -> next instruction loads.
REQ-032 flush=1 with if_valid=1 and ex_ready=0 -> id_ready=1, next ex_valid=0. Opcode 0x3F -> ex_illegal=1, all controls 0.
REQ-033 reset=0 for one edge mid-stall -> all ex_* 0. After release, the first valid instruction appears 1 cycle after acceptance.
